key_sel_ctrl: RTL

//  Debounces one raw, active-low push-button and toggles a registered select

---
 rtl/key_sel_ctrl_if.sv | 18 +
 rtl/key_sel_ctrl.sv | 89 ++++++++
 2 files changed

// File: rtl/key_sel_ctrl_if.sv
// Push-button / mux-select bundle: raw key input plus the registered select and press pulse.
interface key_sel_ctrl_if;
  logic key_in;
  logic sel;
  logic key_flag;

  modport master (
    output key_in,
    input  sel,
    input  key_flag
  );

  modport slave (
    input  key_in,
    output sel,
    output key_flag
  );
endinterface

// File: rtl/key_sel_ctrl.sv
// Debounces an active-low push-button and toggles the downstream mux select on
// every accepted press, with a one-cycle key_flag pulse per press.
module key_sel_ctrl #(
  parameter int unsigned CNT_MAX  = 999_999,
  parameter logic        SEL_INIT = 1'b0
) (
  input  logic           sys_clk,
  input  logic           sys_rst,
  key_sel_ctrl_if.slave  kif
);

  localparam int unsigned CW = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] CNT_TOP = CW'(CNT_MAX);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    P_FILT  = 2'd1,
    PRESSED = 2'd2,
    R_FILT  = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    sync;
  logic          sel_q;
  logic          flag_q;
  logic          key_s;

  assign key_s        = sync[1];
  assign kif.sel      = sel_q;
  assign kif.key_flag = flag_q;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync   <= 2'b11;
      state  <= IDLE;
      cnt    <= '0;
      sel_q  <= SEL_INIT;
      flag_q <= 1'b0;
    end else begin
      sync   <= {sync[0], kif.key_in};
      flag_q <= 1'b0;
      case (state)
        IDLE: begin
          if (!key_s) begin
            state <= P_FILT;
            cnt   <= '0;
          end
        end
        P_FILT: begin
          if (key_s) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_TOP) begin
            state  <= PRESSED;
            cnt    <= '0;
            flag_q <= 1'b1;
            sel_q  <= ~sel_q;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PRESSED: begin
          // Holding never re-arms; only a release can leave this state.
          if (key_s) begin
            state <= R_FILT;
            cnt   <= '0;
          end
        end
        R_FILT: begin
          if (!key_s) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt == CNT_TOP) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
